// File: rtl/dl_stream_demux3.sv
// Streaming 1-to-3 demultiplexer. Each output owns a 2-entry FIFO, so a stalled
// consumer only blocks beats that are selected to its own output.

module dl_stream_demux3_buf #(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic                pop,
   input  logic [NUM_BITS-1:0] wdata,
   output logic                valid,
   output logic                full,
   output logic [NUM_BITS-1:0] rdata
);

   logic [1:0][NUM_BITS-1:0] mem;
   logic [1:0]               cnt;
   logic                     rptr;
   logic                     wptr;
   logic                     do_pop;

   assign valid  = (cnt != 2'd0);
   assign full   = (cnt == 2'd2);
   assign rdata  = mem[rptr];
   // pop carries the consumer's ready; only an occupied buffer actually pops
   assign do_pop = pop && valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem  <= '0;
         cnt  <= 2'd0;
         rptr <= 1'b0;
         wptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wptr] <= wdata;
            wptr      <= ~wptr;
         end
         if (do_pop) rptr <= ~rptr;
         case ({push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

module dl_stream_demux3 #(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] in_data,
   input  logic [1:0]          in_sel,
   output logic                out0_valid,
   input  logic                out0_ready,
   output logic [NUM_BITS-1:0] out0_data,
   output logic                out1_valid,
   input  logic                out1_ready,
   output logic [NUM_BITS-1:0] out1_data,
   output logic                out2_valid,
   input  logic                out2_ready,
   output logic [NUM_BITS-1:0] out2_data
);

   localparam int NUM_OUTS = 3;

   logic [NUM_OUTS-1:0]               full;
   logic [NUM_OUTS-1:0]               valid;
   logic [NUM_OUTS-1:0]               ready;
   logic [NUM_OUTS-1:0]               push;
   logic [NUM_OUTS-1:0][NUM_BITS-1:0] rdata;
   logic [1:0]                        sel_eff;
   logic                              rel;

   // sel 3 folds onto out0, matching the dl_mux3 default leg
   assign sel_eff  = (in_sel == 2'd3) ? 2'd0 : in_sel;
   assign in_ready = rel && !full[sel_eff];
   assign ready    = {out2_ready, out1_ready, out0_ready};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rel <= 1'b0;
      else        rel <= 1'b1;
   end

   for (genvar g = 0; g < NUM_OUTS; g++) begin : g_out
      assign push[g] = in_valid && in_ready && (sel_eff == 2'(g));

      dl_stream_demux3_buf #(.NUM_BITS(NUM_BITS)) u_buf (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[g]),
         .pop   (ready[g]),
         .wdata (in_data),
         .valid (valid[g]),
         .full  (full[g]),
         .rdata (rdata[g])
      );
   end

   assign out0_valid = valid[0];
   assign out1_valid = valid[1];
   assign out2_valid = valid[2];
   assign out0_data  = rdata[0];
   assign out1_data  = rdata[1];
   assign out2_data  = rdata[2];

endmodule

// File: tb/tb_dl_stream_demux3.sv
// Scoreboard bench for dl_stream_demux3: directed scenarios plus a random soak,
// with per-output expected queues filled at acceptance and drained by a monitor.

module tb_dl_stream_demux3;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [1:0]    in_sel = 2'd0;
   logic [2:0]    ov;
   logic [2:0]    ordy = 3'b000;
   logic [W-1:0]  od [3];

   typedef struct {
      logic [W-1:0] d;
      int           t;
   } ent_t;

   ent_t         sb [3][$];
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           rel = 1'b0;
   bit   [2:0]   hold = 3'b000;
   logic [W-1:0] held [3];

   dl_stream_demux3 #(.NUM_BITS(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out0_valid (ov[0]),
      .out0_ready (ordy[0]),
      .out0_data  (od[0]),
      .out1_valid (ov[1]),
      .out1_ready (ordy[1]),
      .out1_data  (od[1]),
      .out2_valid (ov[2]),
      .out2_ready (ordy[2]),
      .out2_data  (od[2])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // One cycle of stimulus; at the falling edge the expected in_ready is derived
   // from scoreboard occupancy (beats accepted but not yet consumed, max 2).
   task automatic step(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [2:0] r, output bit hs);
      int  se;
      bit  exp_rdy;
      ent_t e;
      @(posedge clk);
      if (rst_n) rel = 1'b1;
      #1;
      in_valid = v; in_sel = s; in_data = d; ordy = r;
      @(negedge clk);
      se      = (s == 2'd3) ? 0 : int'(s);
      exp_rdy = rel && (sb[se].size() < 2);
      chk("in_ready", W'(in_ready), W'(exp_rdy));
      hs = v && in_ready;
      if (hs) begin
         e.d = d; e.t = cyc;
         sb[se].push_back(e);
      end
   endtask

   task automatic send(input logic [1:0] s, input logic [W-1:0] d, input logic [2:0] r);
      bit hs = 1'b0;
      int n  = 0;
      while (!hs && n < 50) begin
         step(1'b1, s, d, r, hs);
         n++;
      end
      if (!hs) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: got no accept expected accept for %0h", d);
      end
   endtask

   task automatic idle(input int n);
      bit hs;
      repeat (n) step(1'b0, 2'd0, '0, 3'b111, hs);
   endtask

   // Monitor: checks valid against acceptance time, data order and stability.
   initial begin
      bit exp_v;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            hold = 3'b000;
         end else begin
            for (int i = 0; i < 3; i++) begin
               exp_v = (sb[i].size() > 0) && (sb[i][0].t < cyc);
               chk($sformatf("out%0d_valid", i), W'(ov[i]), W'(exp_v));
               if (hold[i] && ov[i]) chk($sformatf("out%0d_stable", i), od[i], held[i]);
               if (ov[i] && ordy[i] && sb[i].size() > 0) begin
                  chk($sformatf("out%0d_data", i), od[i], sb[i][0].d);
                  void'(sb[i].pop_front());
               end
               hold[i] = ov[i] && !ordy[i];
               held[i] = od[i];
            end
         end
      end
   end

   initial begin
      bit hs;
      int acc, guard;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_valid", W'(ov[i]), '0);
         chk("rst_data", od[i], '0);
      end
      chk("rst_in_ready", W'(in_ready), '0);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("in_ready_pre_edge", W'(in_ready), '0);

      // basic routing
      send(2'd0, 32'hA0, 3'b111);
      send(2'd1, 32'hB1, 3'b111);
      send(2'd2, 32'hC2, 3'b111);
      send(2'd3, 32'hD3, 3'b111);
      idle(4);

      // fill and stall on out1
      send(2'd1, 32'h11, 3'b000);
      send(2'd1, 32'h12, 3'b000);
      step(1'b1, 2'd1, 32'h13, 3'b000, hs);
      step(1'b1, 2'd1, 32'h13, 3'b000, hs);
      send(2'd1, 32'h13, 3'b010);
      idle(4);

      // isolation: out2 full, out0 keeps streaming
      send(2'd2, 32'h21, 3'b001);
      send(2'd2, 32'h22, 3'b001);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 2'd2, 32'h200 + i, 3'b001, hs);
         send(2'd0, 32'h100 + i, 3'b001);
      end
      idle(4);

      // simultaneous push/pop on out0 with one beat resident
      send(2'd0, 32'h55, 3'b000);
      for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'h60 + i, 3'b001, hs);
      idle(4);

      // asynchronous reset with two beats parked in out1
      send(2'd1, 32'h71, 3'b000);
      send(2'd1, 32'h72, 3'b000);
      @(posedge clk); #2 rst_n = 1'b0; rel = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("mid_rst_valid", W'(ov[i]), '0);
         chk("mid_rst_data", od[i], '0);
         sb[i].delete();
      end
      chk("mid_rst_in_ready", W'(in_ready), '0);
      step(1'b1, 2'd1, 32'h73, 3'b000, hs);
      @(posedge clk); #1 rst_n = 1'b1;
      chk("in_ready_pre_edge2", W'(in_ready), '0);
      idle(4);

      // random soak
      acc = 0; guard = 0;
      while (acc < 10000 && guard < 60000) begin
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
              3'($urandom_range(0, 7)), hs);
         if (hs) acc++;
         guard++;
      end
      if (acc < 10000) begin
         n_cmp++; n_bad++;
         $display("FAIL soak_budget: got %0d beats expected 10000", acc);
      end
      idle(10);
      for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), W'(sb[i].size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
